// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window scheduler.
//   - FSM state encoding
//   - default frame geometry, threshold and bus widths
//   - linear-address helper for (row, col) -> buffer address
package sobel_pkg;

    localparam int unsigned SOBEL_IMG_W  = 150;
    localparam int unsigned SOBEL_IMG_H  = 150;
    localparam int unsigned SOBEL_THRESH = 70;
    localparam int unsigned SOBEL_ADDR_W = 15;
    localparam int unsigned SOBEL_PIX_W  = 8;
    localparam int unsigned SOBEL_SLOTS  = 9;
    localparam int unsigned SOBEL_IDX_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_WRITE,
        S_FIN
    } sobel_state_e;

    // Row-major linear address; callers truncate to their address width.
    function automatic logic [31:0] sobel_lin_addr(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] img_w
    );
        return row * img_w + col;
    endfunction

endpackage

// File: rtl/sobel_rd_pipe.sv
// Read-tag pipeline: carries {valid, slot index} alongside each port-A read
// so that data returning RD_LAT cycles later lands in the right window slot.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   i_vld       read strobe issued this cycle
//   i_idx       window slot index of that read
//   o_vld       returned data is valid this cycle
//   o_idx       slot the returned data belongs to
module sobel_rd_pipe
    import sobel_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_vld,
    input  logic [SOBEL_IDX_W-1:0] i_idx,
    output logic                   o_vld,
    output logic [SOBEL_IDX_W-1:0] o_idx
);

    logic                   r_vld [RD_LAT];
    logic [SOBEL_IDX_W-1:0] r_idx [RD_LAT];

    // Shift register, one stage per cycle of read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_vld[i] <= 1'b0;
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_idx[0] <= i_idx;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_vld = r_vld[RD_LAT-1];
    assign o_idx = r_idx[RD_LAT-1];

endmodule

// File: rtl/sobel_window_scheduler.sv
// Sobel window scheduler: walks a 3x3 window over the frame buffer (port A),
// presents each window to the combinational Sobel core, thresholds the
// returned magnitude and writes the edge bit at the window centre (port B).
// Build option: SOBEL_WIN_REUSE_EN -- reuse the two overlapping columns of the
// previous window and fetch only the new right column (3 reads instead of 9).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        pulse: run one pass over the frame
//   busy, done   pass in progress / one-cycle completion pulse
//   rd_en/rd_addr/rd_data      port-A read (data RD_LAT cycles later)
//   win_valid/win_pix          window to Sobel core (slot 0 in LSBs)
//   sobel_mag                  magnitude returned by the core
//   wr_en/wr_addr/wr_data      port-B edge-bit write
module sobel_window_scheduler
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W  = SOBEL_IMG_W,
    parameter int unsigned IMG_H  = SOBEL_IMG_H,
    parameter int unsigned ADDR_W = SOBEL_ADDR_W,
    parameter int unsigned PIX_W  = SOBEL_PIX_W,
    parameter int unsigned THRESH = SOBEL_THRESH,
    parameter int unsigned RD_LAT = 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [PIX_W-1:0]         rd_data,
    output logic                     win_valid,
    output logic [SOBEL_SLOTS*PIX_W-1:0] win_pix,
    input  logic [PIX_W-1:0]         sobel_mag,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     wr_data
);

    sobel_state_e           r_state;
    logic [7:0]             r_x;
    logic [7:0]             r_y;
    logic [1:0]             r_kr;
    logic [1:0]             r_kc;
    logic                   r_full;
    logic                   r_start_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_rd_en;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [SOBEL_IDX_W-1:0] r_rd_idx;
    logic                   r_win_valid;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic                   r_wr_data;
    logic [PIX_W-1:0]       r_slot [SOBEL_SLOTS];

    logic [1:0]             w_nxt_kr;
    logic [1:0]             w_nxt_kc;
    logic [SOBEL_IDX_W-1:0] w_nxt_idx;
    logic                   w_fetch_last;
    logic                   w_row_end;
    logic                   w_last_win;
    logic [7:0]             w_adv_x;
    logic [7:0]             w_adv_y;
    logic                   w_full_new;
    logic [1:0]             w_kc0;
    logic                   w_cap_vld;
    logic [SOBEL_IDX_W-1:0] w_cap_idx;
`ifdef SOBEL_WIN_REUSE_EN
    logic                   w_shift;
`endif

    // Next read position inside the window and window advance.
    always_comb begin
        w_nxt_kr = r_kr;
        w_nxt_kc = r_kc;
        if (!r_full) begin
            // Right-column-only fetch: k = 2, 5, 8.
            w_nxt_kr = r_kr + 2'd1;
            w_nxt_kc = 2'd2;
        end else if (r_kc == 2'd2) begin
            w_nxt_kr = r_kr + 2'd1;
            w_nxt_kc = 2'd0;
        end else begin
            w_nxt_kc = r_kc + 2'd1;
        end
        w_nxt_idx    = {2'b00, w_nxt_kr} * 4'd3 + {2'b00, w_nxt_kc};
        w_fetch_last = (r_kr == 2'd2) && (r_kc == 2'd2);

        w_row_end  = (r_x == 8'(IMG_W - 3));
        w_last_win = w_row_end && (r_y == 8'(IMG_H - 3));
        w_adv_x    = w_row_end ? 8'd0 : r_x + 8'd1;
        w_adv_y    = w_row_end ? r_y + 8'd1 : r_y;
`ifdef SOBEL_WIN_REUSE_EN
        w_full_new = (w_adv_x == 8'd0);
        w_shift    = (r_state == S_WRITE) && !w_last_win && !w_full_new;
`else
        w_full_new = 1'b1;
`endif
        w_kc0 = w_full_new ? 2'd0 : 2'd2;
    end

    sobel_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (r_rd_en),
        .i_idx (r_rd_idx),
        .o_vld (w_cap_vld),
        .o_idx (w_cap_idx)
    );

    // Window slot storage: capture returned pixels; in reuse builds shift the
    // window one column left when stepping along a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SOBEL_SLOTS); k++) begin
                r_slot[k] <= '0;
            end
        end else begin
`ifdef SOBEL_WIN_REUSE_EN
            if (w_shift) begin
                for (int k = 0; k < int'(SOBEL_SLOTS) - 1; k++) begin
                    if ((k % 3) != 2) begin
                        r_slot[k] <= r_slot[k+1];
                    end
                end
            end
`endif
            if (w_cap_vld) begin
                r_slot[w_cap_idx] <= rd_data;
            end
        end
    end

    // Pass sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_kr         <= '0;
            r_kc         <= '0;
            r_full       <= 1'b1;
            r_start_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_idx     <= '0;
            r_win_valid  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start || r_start_pend) begin
                        r_start_pend <= 1'b0;
                        r_state      <= S_FETCH;
                        r_busy       <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_kr         <= '0;
                        r_kc         <= '0;
                        r_full       <= 1'b1;
                        r_rd_en      <= 1'b1;
                        r_rd_addr    <= '0;
                        r_rd_idx     <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_fetch_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_kr      <= w_nxt_kr;
                        r_kc      <= w_nxt_kc;
                        r_rd_idx  <= w_nxt_idx;
                        r_rd_addr <= ADDR_W'(sobel_lin_addr(32'(r_y) + 32'(w_nxt_kr),
                                                            32'(r_x) + 32'(w_nxt_kc),
                                                            32'(IMG_W)));
                    end
                end
                S_DRAIN: begin
                    // Slot 8 is always the last read of a window.
                    if (w_cap_vld && (w_cap_idx == 4'd8)) begin
                        r_state     <= S_EMIT;
                        r_win_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    // win_pix is stable, so the core output is settled here.
                    r_win_valid <= 1'b0;
                    r_wr_en     <= 1'b1;
                    r_wr_data   <= (sobel_mag < PIX_W'(THRESH));
                    r_wr_addr   <= ADDR_W'(sobel_lin_addr(32'(r_y) + 32'd1,
                                                          32'(r_x) + 32'd1,
                                                          32'(IMG_W)));
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    if (w_last_win) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= S_FETCH;
                        r_x       <= w_adv_x;
                        r_y       <= w_adv_y;
                        r_full    <= w_full_new;
                        r_kr      <= 2'd0;
                        r_kc      <= w_kc0;
                        r_rd_en   <= 1'b1;
                        r_rd_idx  <= {2'b00, w_kc0};
                        r_rd_addr <= ADDR_W'(sobel_lin_addr(32'(w_adv_y),
                                                            32'(w_adv_x) + 32'(w_kc0),
                                                            32'(IMG_W)));
                    end
                end
                S_FIN: begin
                    // A start coinciding with done is honoured from IDLE.
                    if (start) begin
                        r_start_pend <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        win_pix = '0;
        for (int k = 0; k < int'(SOBEL_SLOTS); k++) begin
            win_pix[k*PIX_W +: PIX_W] = r_slot[k];
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign win_valid = r_win_valid;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Bench for sobel_window_scheduler: frame buffer and Sobel core models,
// per-pass expected read/window/write streams, cycle-exact pass length.
module tb_sobel_window_scheduler;

    localparam int IMG_W  = 150;
    localparam int IMG_H  = 5;
    localparam int ADDR_W = 15;
    localparam int PIX_W  = 8;
    localparam int THRESH = 70;
    localparam int RD_LAT = 1;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int COLS   = IMG_W - 2;
    localparam int ROWS   = IMG_H - 2;
    localparam int N_WIN  = COLS * ROWS;
`ifdef SOBEL_WIN_REUSE_EN
    localparam bit REUSE   = 1'b1;
    localparam int EXP_CYC = ROWS * ((9 + RD_LAT + 2) + (COLS - 1) * (3 + RD_LAT + 2));
    localparam int EXP_RD  = ROWS * (9 + (COLS - 1) * 3);
    localparam int WRAP_IX = 9 + (COLS - 1) * 3;
`else
    localparam bit REUSE   = 1'b0;
    localparam int EXP_CYC = N_WIN * (9 + RD_LAT + 2);
    localparam int EXP_RD  = N_WIN * 9;
    localparam int WRAP_IX = COLS * 9;
`endif
    localparam int LAST_WA = (IMG_H - 2) * IMG_W + (IMG_W - 2);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done, rd_en, win_valid, wr_en, wr_data;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [71:0]       win_pix;
    logic [PIX_W-1:0]  sobel_mag;

    logic              force_en;
    logic [7:0]        force_val;
    logic [7:0]        frame [NPIX];
    logic [7:0]        mem_pipe [RD_LAT];

    int                n_vec = 0;
    int                n_err = 0;
    int                exp_rd[$];
    logic [71:0]       exp_win[$];
    int                exp_wa[$];
    bit                exp_wd[$];
    int                rd_log[$];
    int                n_rd, n_wr, last_wa, first_wa;
    bit                have_win0, have_wr0, first_wd;
    logic [71:0]       win0;

    always #10 clk = ~clk;

    sobel_window_scheduler #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W),
        .THRESH (THRESH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win_valid (win_valid),
        .win_pix   (win_pix),
        .sobel_mag (sobel_mag),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Plain Sobel: |Gx| + |Gy|, saturated to 8 bits.
    function automatic logic [7:0] sobel_ref(input logic [71:0] w);
        int p[9];
        int gx, gy, m;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 255) m = 255;
        return 8'(m);
    endfunction

    function automatic logic [71:0] win_at(input int x, input int y);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = frame[(y + k/3) * IMG_W + x + k%3];
        return w;
    endfunction

    // Port-A memory with RD_LAT cycles of read latency; junk when not reading.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < NPIX) mem_pipe[0] <= frame[int'(rd_addr)];
        else                               mem_pipe[0] <= 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign rd_data = mem_pipe[RD_LAT-1];

    always_comb sobel_mag = force_en ? force_val : sobel_ref(win_pix);

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0:       frame[i] = 8'(i % 256);
                1:       frame[i] = 8'($urandom_range(0, 255));
                default: frame[i] = 8'(((i % IMG_W) * 3 + (i / IMG_W) * 5) % 200
                                       + int'($urandom_range(0, 8)));
            endcase
        end
    endtask

    // Expected streams for one whole pass, from the frame and the scan order.
    task automatic begin_pass();
        logic [71:0] w;
        int m;
        exp_rd.delete(); exp_win.delete(); exp_wa.delete(); exp_wd.delete();
        rd_log.delete();
        n_rd = 0; n_wr = 0; last_wa = -1; first_wa = -1;
        have_win0 = 0; have_wr0 = 0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                for (int k = 0; k < 9; k++)
                    if (!REUSE || x == 0 || k % 3 == 2)
                        exp_rd.push_back((y + k/3) * IMG_W + x + k%3);
                w = win_at(x, y);
                exp_win.push_back(w);
                exp_wa.push_back((y + 1) * IMG_W + x + 1);
                m = force_en ? int'(force_val) : int'(sobel_ref(w));
                exp_wd.push_back(m < THRESH);
            end
        end
    endtask

    // Compare process: every read, window and write against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rd_en) begin
                n_rd++;
                rd_log.push_back(int'(rd_addr));
                if (exp_rd.size() == 0) chk("rd_unexpected", 72'(rd_en), 72'(0));
                else chk("rd_addr", 72'(rd_addr), 72'(exp_rd.pop_front()));
            end
            if (win_valid) begin
                if (!have_win0) begin win0 = win_pix; have_win0 = 1; end
                if (exp_win.size() == 0) chk("win_unexpected", 72'(win_valid), 72'(0));
                else chk("win_pix", win_pix, exp_win.pop_front());
            end
            if (wr_en) begin
                n_wr++;
                last_wa = int'(wr_addr);
                if (!have_wr0) begin first_wa = int'(wr_addr); first_wd = wr_data; have_wr0 = 1; end
                if (exp_wa.size() == 0) chk("wr_unexpected", 72'(wr_en), 72'(0));
                else begin
                    chk("wr_addr", 72'(wr_addr), 72'(exp_wa.pop_front()));
                    chk("wr_data", 72'(wr_data), 72'(exp_wd.pop_front()));
                end
            end
        end
    end

    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < EXP_CYC + 50) begin
            tick();
            cyc++;
        end
        chk("done_seen", 72'(done), 72'(1));
    endtask

    task automatic run_pass(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        wait_done(cyc);
    endtask

    task automatic end_pass(input int cyc);
        chk("pass_cycles", 72'(cyc), 72'(EXP_CYC + 1));
        chk("busy_at_done", 72'(busy), 72'(0));
        chk("wr_count", 72'(n_wr), 72'(N_WIN));
        chk("rd_count", 72'(n_rd), 72'(EXP_RD));
        chk("last_wr_addr", 72'(last_wa), 72'(LAST_WA));
        chk("rd_left", 72'(exp_rd.size()), 72'(0));
        chk("wr_left", 72'(exp_wa.size()), 72'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 72'(busy), 72'(0));
        chk({tag, "_done"}, 72'(done), 72'(0));
        chk({tag, "_rd_en"}, 72'(rd_en), 72'(0));
        chk({tag, "_rd_addr"}, 72'(rd_addr), 72'(0));
        chk({tag, "_win_valid"}, 72'(win_valid), 72'(0));
        chk({tag, "_win_pix"}, win_pix, 72'(0));
        chk({tag, "_wr_en"}, 72'(wr_en), 72'(0));
        chk({tag, "_wr_addr"}, 72'(wr_addr), 72'(0));
        chk({tag, "_wr_data"}, 72'(wr_data), 72'(0));
    endtask

    initial begin
        int cyc, saved, i;
        int lit_rd[9];
        logic [7:0] lit_px[9];
        logic [71:0] lit_win;
        int fvals[3];
        bit fexp[3];

        rst_n = 1'b0; start = 1'b0; force_en = 1'b0; force_val = 8'd0;
        fill(0);
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 72'(busy), 72'(0));

        // Pass A: address-pattern frame, pinned by hand-computed values.
        fill(0);
        begin_pass();
        run_pass(cyc);
        end_pass(cyc);
        lit_rd = '{0, 1, 2, 150, 151, 152, 300, 301, 302};
        lit_px = '{8'd0, 8'd1, 8'd2, 8'd150, 8'd151, 8'd152, 8'd44, 8'd45, 8'd46};
        for (int k = 0; k < 9; k++) begin
            chk("first_rd_addr", 72'(rd_log[k]), 72'(lit_rd[k]));
            lit_win[k*8 +: 8] = lit_px[k];
        end
        chk("first_win_pix", win0, lit_win);
        chk("first_wr_addr", 72'(first_wa), 72'(151));
        chk("first_wr_data", 72'(first_wd), 72'(0));
        chk("row_end_last_rd", 72'(rd_log[WRAP_IX-1]), 72'(449));
        chk("row_wrap_rd", 72'(rd_log[WRAP_IX]), 72'(150));
        tick();
        chk("done_one_cycle", 72'(done), 72'(0));
        tick();

        // Pass B: random frame, start pulsed mid-pass must be ignored.
        fill(1);
        begin_pass();
        start = 1'b1; tick(); start = 1'b0;
        cyc = 1;
        repeat (100) begin tick(); cyc++; end
        start = 1'b1; tick(); cyc++; start = 1'b0;
        wait_done(cyc);
        end_pass(cyc);

        // Start in the done cycle: next pass launched from IDLE.
        start = 1'b1;
        fill(2);
        begin_pass();
        tick();
        start = 1'b0;
        chk("done_start_idle_busy", 72'(busy), 72'(0));
        chk("done_start_idle_rd_en", 72'(rd_en), 72'(0));
        tick();
        chk("done_start_busy", 72'(busy), 72'(1));
        chk("done_start_rd_en", 72'(rd_en), 72'(1));
        chk("done_start_rd_addr", 72'(rd_addr), 72'(0));
        cyc = 1;
        wait_done(cyc);
        end_pass(cyc);
        repeat (2) tick();

        // Pass D: reset during the fifth window aborts the pass.
        fill(1);
        begin_pass();
        start = 1'b1; tick(); start = 1'b0;
        i = 0;
        while (n_wr < 4 && i < 400) begin tick(); i++; end
        chk("abort_writes_before", 72'(n_wr), 72'(4));
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk_all_zero("midreset");
        exp_rd.delete(); exp_win.delete(); exp_wa.delete(); exp_wd.delete();
        saved = n_wr;
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("abort_no_writes", 72'(n_wr), 72'(saved));
        chk("abort_idle_busy", 72'(busy), 72'(0));

        // Pass E: fresh pass after reset begins at the origin.
        fill(2);
        begin_pass();
        run_pass(cyc);
        end_pass(cyc);
        chk("post_reset_first_rd", 72'(rd_log[0]), 72'(0));
        chk("post_reset_first_wa", 72'(first_wa), 72'(IMG_W + 1));
        repeat (2) tick();

        // Threshold boundary with the core output forced.
        fvals = '{69, 70, 255};
        fexp  = '{1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            force_en  = 1'b1;
            force_val = 8'(fvals[t]);
            fill(1);
            begin_pass();
            run_pass(cyc);
            end_pass(cyc);
            chk("thresh_first_wd", 72'(first_wd), 72'(fexp[t]));
            repeat (2) tick();
        end
        force_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window_scheduler.md
Name: sobel_window_scheduler

Overview:
Sequences the 3x3 Sobel kernel over the 150x150 grayscale frame buffer (port A). It issues buffer read addresses and collects the nine window pixels. It presents each window to the combinational Sobel core, thresholds the returned magnitude, and writes the 1-bit edge result into the edge buffer (port B) at the window-centre address. A start/done handshake lets the frame-capture logic run one full Sobel pass per captured frame.

Parameters:
IMG_W, 150, frame width in pixels
IMG_H, 150, frame height in pixels
ADDR_W, 15, buffer address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)
PIX_W, 8, grayscale pixel width
THRESH, 70, magnitude threshold; mag < THRESH writes 1
RD_LAT, 1, buffer read latency in clk cycles (1..3)

Ports:
clk  in  1  system clock (50 MHz domain)
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: begin a Sobel pass over the frame
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last result write
rd_en  out  1  port-A read strobe
rd_addr  out  ADDR_W  port-A read address
rd_data  in  PIX_W  port-A read data, valid RD_LAT cycles after rd_en
win_valid  out  1  one-cycle pulse: win_pix holds a complete window
win_pix  out  9*PIX_W  window, row-major; slot k = row k/3, col k%3; slot 0 in LSBs
sobel_mag  in  PIX_W  Sobel core magnitude (combinational from win_pix)
wr_en  out  1  port-B write strobe
wr_addr  out  ADDR_W  port-B write address
wr_data  out  1  thresholded edge bit

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. busy, done, rd_en, win_valid, wr_en, wr_data, rd_addr, wr_addr = 0. win_pix = 0. Window origin x=y=0. Reset mid-pass aborts the pass immediately; no further writes occur.
- FSM states: IDLE -> FETCH -> DRAIN -> EMIT -> WRITE -> (FETCH | FIN) ; FIN -> IDLE.
- IDLE: start=1 -> FETCH, x=y=0, busy=1 next cycle. start while busy is ignored (not queued).
- FETCH: read index k counts 0..8, one read per cycle. rd_en=1, rd_addr=(y+k/3)*IMG_W + x + k%3. After k=8 -> DRAIN.
- Capture: rd_data arriving RD_LAT cycles after each rd_en is stored in slot k (tracked by a delayed index pipeline).
- DRAIN: lasts RD_LAT cycles with rd_en=0, until slot 8 is captured; then -> EMIT.
- EMIT: win_valid=1 for exactly one cycle; win_pix is stable from this cycle through WRITE.
- WRITE: samples sobel_mag. wr_en=1 for one cycle. wr_addr=(y+1)*IMG_W + x+1. wr_data = (sobel_mag < THRESH).
- Advance after WRITE: x<IMG_W-3 -> x+1. Otherwise x=0 and y+1. If y was IMG_H-3 -> FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Windows per pass: (IMG_W-2)*(IMG_H-2) = 21904 at defaults.
- Cycles per window (base build): 9 + RD_LAT + 2, i.e. 12 at RD_LAT=1.
- Border pixels (row/col 0 and IMG_W-1 / IMG_H-1) are never written.
- Arithmetic: addresses are computed at ADDR_W bits with no truncation; max address IMG_W*IMG_H-1. x and y are 8-bit counters.
- start in the same cycle as done is accepted (FIN->FETCH is not allowed; the start is registered and acted on from IDLE the next cycle).

Optional Feature:
SOBEL_WIN_REUSE_EN
- Defined:
  - On x>0, slots shift left by one column (slot k <- slot k+1 for k%3 != 2).
  - Only the new right column is fetched: 3 reads, k=2,5,8.
  - The first window of each row still does 9 reads.
  - Steady-state cost is 3 + RD_LAT + 2 cycles per window.
  - Written results are bit-identical to the base build.
- Undefined: 9 reads for every window, as in the base behaviour.

Decomposition:
- Shared package sobel_pkg holds:
  - FSM state enum (IDLE, FETCH, DRAIN, EMIT, WRITE, FIN)
  - default constants IMG_W, IMG_H, THRESH
  - helper function for (row, col) -> linear address
- One natural sub-module: sobel_rd_pipe. It is an RD_LAT-deep shift register carrying {valid, slot index} alongside reads, so that returned data lands in the correct slot.

Test Plan:
- Reset mid-pass: assert rst_n=0 during window 5 -> next cycle all outputs 0, no wr_en afterward, state IDLE. Then start -> pass begins at x=y=0.
- First window: start with buffer preloaded addr=value%256 -> rd_addr sequence 0,1,2,150,151,152,300,301,302. win_pix slots equal those values. wr_addr=151.
- Threshold boundary: sobel_mag forced to 69 -> wr_data=1; forced to 70 -> wr_data=0; forced to 255 -> wr_data=0.
- Row wrap and end: check the window at x=147,y=0 is followed by x=0,y=1 (rd_addr 150 first). Last wr_addr=148*150+148=22348. done pulses once; exactly 21904 wr_en pulses; total cycles 21904*12 (+/-2 for handshake) at RD_LAT=1.
- Start while busy: pulse start mid-pass -> no restart, write count unchanged. Start in the done cycle -> second pass begins from IDLE.
- SOBEL_WIN_REUSE_EN: same preloaded frame -> port-B contents identical to the base build. Reads per pass = 148*9 + 148*147*3.
